// File: rtl/mem_stage_mc_if.sv
// Bundle between the execute/memory pipeline registers and the memory stage.
// master drives requests and branch inputs; slave returns stall, data, branch.
interface mem_stage_mc_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rd_mem;
  logic            regwrite_mem;
  logic            memtoreg_mem;
  logic            memread_mem;
  logic            memwrite_mem;
  logic            branch_mem;
  logic [2:0]      funct3_mem;
  logic            zero_mem;
  logic            lt_mem;
  logic            ltu_mem;
  logic [XLEN-1:0] alu_out_mem;
  logic [XLEN-1:0] pc_branch_mem;
  logic [XLEN-1:0] reg_data2_mem_final;
  logic            pcsrc_if;
  logic [XLEN-1:0] pc_branch_if;
  logic [XLEN-1:0] read_data;
  logic            stall_mem;
  logic            misalign_mem;

  modport master (
    output rd_mem, regwrite_mem, memtoreg_mem,
    output memread_mem, memwrite_mem, branch_mem,
    output funct3_mem, zero_mem, lt_mem, ltu_mem,
    output alu_out_mem, pc_branch_mem,
    output reg_data2_mem_final,
    input  pcsrc_if, pc_branch_if, read_data,
    input  stall_mem, misalign_mem
  );

  modport slave (
    input  rd_mem, regwrite_mem, memtoreg_mem,
    input  memread_mem, memwrite_mem, branch_mem,
    input  funct3_mem, zero_mem, lt_mem, ltu_mem,
    input  alu_out_mem, pc_branch_mem,
    input  reg_data2_mem_final,
    output pcsrc_if, pc_branch_if, read_data,
    output stall_mem, misalign_mem
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: byte-lane data memory, fixed latency, branch resolve.
// Ports: clk, rst_n (async low), bus (mem_stage_mc_if.slave).
module mem_stage_mc #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int MEM_LATENCY = 2
) (
  input logic         clk,
  input logic         rst_n,
  mem_stage_mc_if.slave bus
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rdata;

  logic [AW-1:0]   idx;
  logic [OFF-1:0]  off;
  logic [OFF-1:0]  amask;
  logic [1:0]      sz;
  logic            uns;
  logic            req, mis, go;
  logic            commit, we, ld_en;
  logic [XLEN-1:0] word, sh, ld_val, wd;
  logic [15:0]     lanes;
  logic [NB-1:0]   be;
  logic            cond;
  logic            unused;

  assign idx = bus.alu_out_mem[OFF+AW-1:OFF];
  assign off = bus.alu_out_mem[OFF-1:0];
  assign req = bus.memread_mem | bus.memwrite_mem;

  always_comb begin
    sz  = 2'd2;
    uns = 1'b0;
    unique case (bus.funct3_mem)
      3'b000: sz = 2'd0;
      3'b001: sz = 2'd1;
      3'b100: begin sz = 2'd0; uns = 1'b1; end
      3'b101: begin sz = 2'd1; uns = 1'b1; end
      3'b110: uns = 1'b1;
      3'b011: sz = (XLEN == 64) ? 2'd3 : 2'd2;
      default: sz = 2'd2;
    endcase
  end

  assign amask = OFF'((4'd1 << sz) - 4'd1);
  assign mis   = req & (|(off & amask));
  assign go    = req & ~mis;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          if (MEM_LATENCY == 1) begin
            state_n = DONE;
            commit  = 1'b1;
          end else begin
            state_n = BUSY;
            cnt_n   = 4'(MEM_LATENCY - 1);
          end
        end
      end
      BUSY: begin
        // commit on the edge where the count reaches zero
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = DONE;
          commit  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // store wins when both request bits are set
  assign we    = commit & bus.memwrite_mem & rst_n;
  assign ld_en = commit & bus.memread_mem & ~bus.memwrite_mem;

  assign word = mem[idx];
  assign sh   = word >> {off, 3'b000};

  always_comb begin
    unique case (sz)
      2'd0: ld_val = uns ? XLEN'(sh[7:0])
                         : XLEN'($signed(sh[7:0]));
      2'd1: ld_val = uns ? XLEN'(sh[15:0])
                         : XLEN'($signed(sh[15:0]));
      2'd2: ld_val = uns ? XLEN'(sh[31:0])
                         : XLEN'($signed(sh[31:0]));
      default: ld_val = sh;
    endcase
  end

  always_comb begin
    unique case (sz)
      2'd0: lanes = 16'h0001;
      2'd1: lanes = 16'h0003;
      2'd2: lanes = 16'h000f;
      default: lanes = 16'h00ff;
    endcase
  end

  assign be = NB'(lanes << off);
  assign wd = bus.reg_data2_mem_final << {off, 3'b000};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (ld_en) begin
      rdata <= ld_val;
    end else if (state == IDLE && mis) begin
      rdata <= '0;
    end
  end

  always_comb begin
    cond = 1'b0;
    unique case (bus.funct3_mem)
      3'b000: cond = bus.zero_mem;
      3'b001: cond = ~bus.zero_mem;
      3'b100: cond = bus.lt_mem;
      3'b101: cond = ~bus.lt_mem;
      3'b110: cond = bus.ltu_mem;
      3'b111: cond = ~bus.ltu_mem;
      default: cond = 1'b0;
    endcase
  end

  assign bus.pcsrc_if     = bus.branch_mem & cond;
  assign bus.pc_branch_if = bus.pc_branch_mem;
  assign bus.read_data    = rdata;
  assign bus.misalign_mem = mis;
  assign bus.stall_mem    = ((state == IDLE) & go)
                          | (state == BUSY);

  assign unused = ^{bus.rd_mem, bus.regwrite_mem,
                    bus.memtoreg_mem,
                    bus.alu_out_mem[XLEN-1:OFF+AW]};
endmodule

// File: tb/tb_mem_stage_mc.sv
// Scoreboard bench for mem_stage_mc (XLEN=32, DEPTH=1024, MEM_LATENCY=2).
// Stimulus pushes expected load data; a monitor pops on DONE / after misalign.
module tb_mem_stage_mc;
  localparam int ML = 2;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  mem_stage_mc_if #(.XLEN(32)) bus();

  mem_stage_mc #(
    .XLEN(32), .DEPTH(1024), .MEM_LATENCY(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  initial begin : monitor
    logic sp, mp;
    exp_t e;
    sp = 1'b0;
    mp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sp = 1'b0;
        mp = 1'b0;
      end else begin
        if ((sp && !bus.stall_mem && bus.memread_mem
             && !bus.memwrite_mem) || mp) begin
          if (sb.size() == 0) begin
            chk("sb_empty_pop", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk(e.nm, bus.read_data, e.v);
          end
        end
        sp = bus.stall_mem;
        mp = bus.misalign_mem;
      end
    end
  end

  task automatic idle_in();
    bus.rd_mem = 5'd0;
    bus.regwrite_mem = 1'b0;
    bus.memtoreg_mem = 1'b0;
    bus.memread_mem = 1'b0;
    bus.memwrite_mem = 1'b0;
    bus.branch_mem = 1'b0;
    bus.funct3_mem = 3'b000;
    bus.zero_mem = 1'b0;
    bus.lt_mem = 1'b0;
    bus.ltu_mem = 1'b0;
    bus.alu_out_mem = '0;
    bus.pc_branch_mem = '0;
    bus.reg_data2_mem_final = '0;
  endtask

  task automatic access(input logic r, input logic w,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int exp_stall,
                        input string nm);
    int n;
    bit done;
    @(posedge clk); #1;
    bus.memread_mem = r;
    bus.memwrite_mem = w;
    bus.funct3_mem = f3;
    bus.alu_out_mem = a;
    bus.reg_data2_mem_final = d;
    bus.rd_mem = 5'd7;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.stall_mem) n++;
      else done = 1'b1;
    end
    if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
    chk({nm, "_stall"}, 32'(n), 32'(exp_stall));
    if (exp_stall == 0)
      chk({nm, "_mis"}, 32'(bus.misalign_mem), 32'd1);
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic store(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input string nm);
    access(1'b0, 1'b1, f3, a, d, ML, nm);
  endtask

  task automatic load(input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] v,
                      input string nm);
    exp_t e;
    e.nm = nm;
    e.v = v;
    sb.push_back(e);
    access(1'b1, 1'b0, f3, a, 32'd0, ML, nm);
  endtask

  task automatic misal(input logic r, input logic w,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input string nm);
    exp_t e;
    e.nm = {nm, "_rd0"};
    e.v = 32'd0;
    sb.push_back(e);
    access(r, w, f3, a, 32'hFFFF_FFFF, 0, nm);
  endtask

  task automatic br(input logic [2:0] f3,
                    input logic z, input logic l,
                    input logic lu,
                    input logic [31:0] pc,
                    input logic want, input string nm);
    bus.branch_mem = 1'b1;
    bus.funct3_mem = f3;
    bus.zero_mem = z;
    bus.lt_mem = l;
    bus.ltu_mem = lu;
    bus.pc_branch_mem = pc;
    #1;
    chk({nm, "_pcsrc"}, 32'(bus.pcsrc_if), 32'(want));
    chk({nm, "_pc"}, bus.pc_branch_if, pc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.read_data, 32'd0);
    chk("rst_stall", 32'(bus.stall_mem), 32'd0);
    chk("rst_mis", 32'(bus.misalign_mem), 32'd0);
    rst_n = 1'b1;

    store(3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10");
    load(3'b010, 32'h10, 32'hDEAD_BEEF, "lw_10");
    store(3'b000, 32'h13, 32'h0000_0080, "sb_13");
    load(3'b000, 32'h13, 32'hFFFF_FF80, "lb_13");
    load(3'b100, 32'h13, 32'h0000_0080, "lbu_13");
    load(3'b001, 32'h12, 32'hFFFF_80AD, "lh_12");
    load(3'b101, 32'h10, 32'h0000_BEEF, "lhu_10");
    load(3'b010, 32'h10, 32'h80AD_BEEF, "lw_10b");

    misal(1'b1, 1'b0, 3'b010, 32'h12, "lw_12");
    load(3'b010, 32'h10, 32'h80AD_BEEF, "lw_10c");
    misal(1'b0, 1'b1, 3'b001, 32'h11, "sh_11");
    load(3'b010, 32'h10, 32'h80AD_BEEF, "lw_10d");

    access(1'b1, 1'b1, 3'b010, 32'h30,
           32'hCAFE_F00D, ML, "rw_30");
    chk("rw_keep", bus.read_data, 32'h80AD_BEEF);
    load(3'b010, 32'h30, 32'hCAFE_F00D, "lw_30");

    store(3'b010, 32'h20, 32'h1234_5678, "sw_20");
    @(posedge clk); #1;
    bus.memwrite_mem = 1'b1;
    bus.funct3_mem = 3'b010;
    bus.alu_out_mem = 32'h20;
    bus.reg_data2_mem_final = 32'h1;
    @(negedge clk);
    chk("abort_acc_stall", 32'(bus.stall_mem), 32'd1);
    @(negedge clk);
    chk("abort_busy_stall", 32'(bus.stall_mem), 32'd1);
    rst_n = 1'b0;
    idle_in();
    #1;
    chk("abort_stall", 32'(bus.stall_mem), 32'd0);
    chk("abort_rdata", bus.read_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(3'b010, 32'h20, 32'h1234_5678, "lw_20");

    store(3'b010, 32'h1000, 32'h0000_0055, "sw_1000");
    load(3'b010, 32'h0, 32'h0000_0055, "lw_0_wrap");

    br(3'b101, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 1'b0, "bge");
    br(3'b110, 1'b0, 1'b0, 1'b1, 32'h0000_8004, 1'b1, "bltu");
    br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, "beq");
    br(3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, "f010");
    br(3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b1, "bgeu");
    bus.branch_mem = 1'b0;
    #1;
    chk("nobr_pcsrc", 32'(bus.pcsrc_if), 32'd0);
    idle_in();

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_mc.md
MEM_STAGE_MC -- requirements
Module: mem_stage_mc

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the data/address width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 1024, the number of XLEN-bit memory words; it SHALL be a power of two.
REQ-003 The block SHALL have parameter MEM_LATENCY, default 2, the number of stall cycles per access; the legal range is 1..8.
REQ-004 clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  is the asynchronous, active-low reset.
REQ-006 The block SHALL have these ports:
- rd_mem  in  5  destination register, passed through unused for sideband.
- regwrite_mem, memtoreg_mem  in  1  pass-through control, unused internally.
- memread_mem, memwrite_mem  in  1  load and store requests.
- branch_mem  in  1  branch instruction flag.
- funct3_mem  in  3  access size and sign for loads/stores; condition for branches.
- zero_mem, lt_mem, ltu_mem  in  1  ALU equal, signed-less-than and unsigned-less-than flags.
- alu_out_mem  in  XLEN  byte address.
- pc_branch_mem  in  XLEN  branch target.
- reg_data2_mem_final  in  XLEN  store data.
- pcsrc_if  out  1  take branch.
- pc_branch_if  out  XLEN  branch target to fetch.
- read_data  out  XLEN  extended load result.
- stall_mem  out  1  freeze upstream pipeline.
- misalign_mem  out  1  misaligned access flag.

Function
REQ-007 Memory SHALL be DEPTH words, byte-addressed little-endian, with word index = alu_out_mem[log2(XLEN/8)+log2(DEPTH)-1 : log2(XLEN/8)]; upper address bits SHALL be ignored so that addresses wrap modulo the memory size.
REQ-008 Access size SHALL be decoded from funct3_mem as follows, with sign extension to XLEN:
- 000 byte (signed); 001 half (signed); 010 word (signed when XLEN=64).
- 100 byte unsigned; 101 half unsigned; 110 word unsigned.
- 011 doubleword; legal only when XLEN=64.
- Any other code SHALL be treated as 010.
REQ-009 Stores SHALL write only the addressed byte lanes; all other bytes in the word SHALL be unchanged.
REQ-010 misalign_mem SHALL be combinational: 1 when (memread_mem|memwrite_mem) and the address is not a multiple of the access size; otherwise 0.
REQ-011 A misaligned access SHALL perform no write, cause no stall, and produce read_data=0 in the following cycle.
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
- IDLE -> BUSY when an aligned request is present; counter loads MEM_LATENCY-1.
- IDLE -> IDLE otherwise.
REQ-013 In BUSY, the counter SHALL decrement each cycle; at counter=0 the state SHALL go to DONE.
- A store SHALL commit on that edge.
- A load SHALL register its extended result into read_data on that edge.
REQ-014 With MEM_LATENCY=1, the acceptance cycle SHALL also be the commit cycle.
REQ-015 stall_mem SHALL be combinational = (IDLE & aligned request) | BUSY.
- A request accepted in cycle t SHALL stall cycles t..t+MEM_LATENCY-1.
- Stall SHALL be 0 in cycle t+MEM_LATENCY (DONE).
REQ-016 DONE SHALL ignore all request inputs, because they still hold the completed instruction, and SHALL return to IDLE unconditionally; back-to-back accesses therefore cost MEM_LATENCY+1 cycles each.
REQ-017 read_data SHALL hold its last value until the next load completes or a misaligned access occurs.
REQ-018 When memread_mem and memwrite_mem are both 1, the access SHALL be performed as a store and read_data SHALL be unchanged.
REQ-019 Request inputs SHALL be sampled every cycle while in BUSY; upstream is required to hold them stable while stalled.
REQ-020 pcsrc_if SHALL be combinational = branch_mem & cond, where cond by funct3_mem is:
- 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
- 010 and 011 give 0.
REQ-021 pc_branch_if SHALL equal pc_branch_mem combinationally.

Reset
REQ-022 While rst_n=0, state SHALL be IDLE, the counter 0 and read_data 0, and the memory array SHALL NOT be cleared.
REQ-023 Reset asserted during BUSY SHALL abort the access; a store not yet committed SHALL NOT be written.
REQ-024 Release of rst_n SHALL take effect at the next rising clk edge.

Verification
REQ-025 SW 0xDEADBEEF to 0x10, then LW 0x10 with MEM_LATENCY=2 -> stall_mem=1 for 2 cycles then 0; read_data=0xDEADBEEF in the DONE cycle.
REQ-026 SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-027 LW 0x12 -> misalign_mem=1, stall_mem=0, read_data=0; memory unchanged.
REQ-028 rst_n pulsed low during BUSY of SW 0x1 to 0x20 -> state IDLE, stall_mem=0; a subsequent LW 0x20 returns the prior contents.
REQ-029 branch_mem=1, funct3=101, lt=1 -> pcsrc_if=0; funct3=110, ltu=1 -> pcsrc_if=1; pc_branch_if tracks pc_branch_mem in both.
REQ-030 DEPTH=1024: SW 0x55 to 0x1000, then LW 0x0 -> 0x55 (address wrap).
